mac_normalize_pipe: RTL

MAC_NORMALIZE_PIPE -- requirements
Module: mac_normalize_pipe

---
 rtl/mac_normalize_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mac_normalize_pipe.sv
// Two-stage normalizer for an aligned MAC sum: S1 captures the beat plus its
// leading-one position, S2 shifts the mantissa up and produces the exponent adjust.
module mac_normalize_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] sum_mag,
  input  logic        sign,
  input  logic [5:0]  max_exp,
  input  logic [4:0]  Q_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] norm_sum_with_leading1,
  output logic [4:0]  signed_exp_diff,
  output logic        exp_carry,
  output logic        sign_o,
  output logic [5:0]  max_exp_o,
  output logic [4:0]  Q_frac_o,
  output logic [50:0] number
);

  logic        s1Valid_q, s1Valid_d;
  logic [11:0] s1Mag_q, s1Mag_d;
  logic        s1Sign_q, s1Sign_d;
  logic [5:0]  s1MaxExp_q, s1MaxExp_d;
  logic [4:0]  s1QFrac_q, s1QFrac_d;
  logic [3:0]  s1Pos_q, s1Pos_d;

  logic        s2Valid_q, s2Valid_d;
  logic [10:0] s2Norm_q, s2Norm_d;
  logic [4:0]  s2Diff_q, s2Diff_d;
  logic        s2Carry_q, s2Carry_d;
  logic        s2Sign_q, s2Sign_d;
  logic [5:0]  s2MaxExp_q, s2MaxExp_d;
  logic [4:0]  s2QFrac_q, s2QFrac_d;

  logic        s1Load, s2Load;
  logic [3:0]  leadPos;
  logic [3:0]  shiftAmt;
  logic [10:0] normCalc;
  logic [4:0]  diffCalc;
  logic        carryCalc;

  // S2 can take a beat when it is empty or its beat leaves this cycle.
  assign s2Load   = !s2Valid_q || out_ready;
  assign in_ready = !s1Valid_q || s2Load;
  assign s1Load   = in_valid && in_ready;

  // Highest set bit among 0..10; bit 11 is handled separately as the carry case.
  always_comb begin
    leadPos = '0;
    for (int i = 0; i < 11; i++) begin
      if (sum_mag[i]) leadPos = 4'(i);
    end
  end

  always_comb begin
    shiftAmt  = 4'd10 - s1Pos_q;
    normCalc  = '0;
    diffCalc  = '0;
    carryCalc = 1'b0;
    if (s1Mag_q[11]) begin
      normCalc  = s1Mag_q[11:1];
      carryCalc = 1'b1;
    end else if (s1Mag_q != 12'd0) begin
      normCalc = s1Mag_q[10:0] << shiftAmt;
      diffCalc = 5'd0 - {1'b0, shiftAmt};
    end
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Mag_d    = s1Mag_q;
    s1Sign_d   = s1Sign_q;
    s1MaxExp_d = s1MaxExp_q;
    s1QFrac_d  = s1QFrac_q;
    s1Pos_d    = s1Pos_q;
    if (s1Load) begin
      s1Valid_d  = 1'b1;
      s1Mag_d    = sum_mag;
      s1Sign_d   = sign;
      s1MaxExp_d = max_exp;
      s1QFrac_d  = Q_frac;
      s1Pos_d    = leadPos;
    end else if (s2Load) begin
      s1Valid_d = 1'b0;
    end
  end

  always_comb begin
    s2Valid_d  = s2Valid_q;
    s2Norm_d   = s2Norm_q;
    s2Diff_d   = s2Diff_q;
    s2Carry_d  = s2Carry_q;
    s2Sign_d   = s2Sign_q;
    s2MaxExp_d = s2MaxExp_q;
    s2QFrac_d  = s2QFrac_q;
    if (s2Load) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Norm_d   = normCalc;
        s2Diff_d   = diffCalc;
        s2Carry_d  = carryCalc;
        s2Sign_d   = s1Sign_q;
        s2MaxExp_d = s1MaxExp_q;
        s2QFrac_d  = s1QFrac_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Mag_q    <= '0;
      s1Sign_q   <= 1'b0;
      s1MaxExp_q <= '0;
      s1QFrac_q  <= '0;
      s1Pos_q    <= '0;
      s2Valid_q  <= 1'b0;
      s2Norm_q   <= '0;
      s2Diff_q   <= '0;
      s2Carry_q  <= 1'b0;
      s2Sign_q   <= 1'b0;
      s2MaxExp_q <= '0;
      s2QFrac_q  <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Mag_q    <= s1Mag_d;
      s1Sign_q   <= s1Sign_d;
      s1MaxExp_q <= s1MaxExp_d;
      s1QFrac_q  <= s1QFrac_d;
      s1Pos_q    <= s1Pos_d;
      s2Valid_q  <= s2Valid_d;
      s2Norm_q   <= s2Norm_d;
      s2Diff_q   <= s2Diff_d;
      s2Carry_q  <= s2Carry_d;
      s2Sign_q   <= s2Sign_d;
      s2MaxExp_q <= s2MaxExp_d;
      s2QFrac_q  <= s2QFrac_d;
    end
  end

  assign out_valid              = s2Valid_q;
  assign norm_sum_with_leading1 = s2Norm_q;
  assign signed_exp_diff        = s2Diff_q;
  assign exp_carry              = s2Carry_q;
  assign sign_o                 = s2Sign_q;
  assign max_exp_o              = s2MaxExp_q;
  assign Q_frac_o               = s2QFrac_q;
  // No sub-cells are instantiated, so the aggregated cell count is zero.
  assign number                 = '0;

endmodule
